// File: rtl/pending_encoder.sv
// pending_encoder: collects request pulses into a pending register and hands
// out one binary index per valid/ready handshake, clearing each bit as its
// index is accepted. Selection is round-robin from a pointer that advances past
// the last accepted index. Define ENC_FIXED_PRIORITY_EN to select the lowest
// pending index instead; the round-robin pointer is then not built.
module pending_encoder #(
    parameter int LEN = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2**LEN-1:0]   req_i,
    input  logic                ready_i,
    output logic [LEN-1:0]      idx_o,
    output logic                valid_o,
    output logic [2**LEN-1:0]   pending_o
);

    localparam int N = 2**LEN;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   pend;
    logic [N-1:0]   pend_next;
    logic [N-1:0]   srv;
    logic [N-1:0]   cand;
    logic           acc;
    logic [LEN-1:0] idx_next;
    logic [LEN-1:0] scan_base;
    logic [LEN-1:0] sel;
    logic           sel_found;

`ifndef ENC_FIXED_PRIORITY_EN
    logic [LEN-1:0] ptr;
    logic [LEN-1:0] ptr_next;
`endif

    // Retire the offered index on a handshake; new requests are OR'd in afterwards so set beats clear
    always_comb begin
        acc       = (state == HOLD) & ready_i;
        srv       = '0;
        if (acc) begin
            srv[idx_o] = 1'b1;
        end
        cand      = pend & ~srv;
        pend_next = cand | req_i;
    end

    // Pick where the selector starts scanning: the bit after a just-accepted index, else the stored pointer
    always_comb begin
`ifdef ENC_FIXED_PRIORITY_EN
        scan_base = '0;
`else
        scan_base = acc ? (idx_o + LEN'(1)) : ptr;
`endif
    end

    // Find the first candidate at or above scan_base, wrapping around the top of the vector
    always_comb begin
        logic [LEN-1:0] k;
        k         = '0;
        sel       = '0;
        sel_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = scan_base + LEN'(i);
            if (!sel_found && cand[k]) begin
                sel       = k;
                sel_found = 1'b1;
            end
        end
    end

    // Offer/hold FSM: idx_o only changes when entering HOLD or on an accepted handshake
    always_comb begin
        state_next = state;
        idx_next   = idx_o;
`ifndef ENC_FIXED_PRIORITY_EN
        ptr_next   = ptr;
`endif
        case (state)
            IDLE: begin
                if (sel_found) begin
                    idx_next   = sel;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (acc) begin
`ifndef ENC_FIXED_PRIORITY_EN
                    ptr_next = idx_o + LEN'(1);
`endif
                    if (sel_found) begin
                        idx_next = sel;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, pending and index registers; reset clears everything immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pend  <= '0;
            idx_o <= '0;
        end else begin
            state <= state_next;
            pend  <= pend_next;
            idx_o <= idx_next;
        end
    end

`ifndef ENC_FIXED_PRIORITY_EN
    // Round-robin pointer, advanced only by accepted handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end
`endif

    assign valid_o   = (state == HOLD);
    assign pending_o = pend;

endmodule
